// File: rtl/fpga_iser_align.sv
// Multi-lane word aligner that sits behind the per-pin ISERDES primitives.
// Each lane slides a 2-word window one bit at a time until the training
// word repeats LOCK_CNT times in a row. It then holds lock until UNLOCK_CNT
// consecutive training mismatches occur. Aligned data is forwarded in every
// state; downstream logic gates on lane_locked.
module fpga_iser_align #(
    parameter int              DW         = 8,
    parameter int              LANES      = 4,
    parameter logic [DW-1:0]   TRAIN      = 8'h6A,
    parameter int              LOCK_CNT   = 16,
    parameter int              UNLOCK_CNT = 4
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic [LANES*DW-1:0]          din,
    input  logic                         din_vld,
    input  logic                         train_en,
    input  logic                         realign,
    output logic [LANES*DW-1:0]          dout,
    output logic                         dout_vld,
    output logic [LANES-1:0]             lane_locked,
    output logic                         all_locked,
    output logic [LANES*$clog2(DW)-1:0]  slip_pos
);

    localparam int SW   = $clog2(DW);
    localparam int CMAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [SW-1:0] SLIP_LAST = SW'(DW - 1);
    localparam logic [CW-1:0] LOCK_C    = CW'(LOCK_CNT);
    localparam logic [CW-1:0] UNLOCK_C  = CW'(UNLOCK_CNT);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e                 state_q     [LANES];
    state_e                 state_d     [LANES];
    logic [SW-1:0]          slip_q      [LANES];
    logic [SW-1:0]          slip_d      [LANES];
    logic [CW-1:0]          match_cnt_q [LANES];
    logic [CW-1:0]          match_cnt_d [LANES];
    logic [CW-1:0]          err_cnt_q   [LANES];
    logic [CW-1:0]          err_cnt_d   [LANES];
    logic [DW-1:0]          prev_q      [LANES];
    logic [DW-1:0]          prev_d      [LANES];
    logic [2*DW-1:0]        win_s       [LANES];
    logic [DW-1:0]          aligned_s   [LANES];
    logic                   match_s     [LANES];

    logic [LANES*DW-1:0]    dout_q;
    logic [LANES*DW-1:0]    dout_d;
    logic                   dout_vld_q;
    logic                   dout_vld_d;
    logic [LANES-1:0]       locked_q;
    logic [LANES-1:0]       locked_d;
    logic                   all_locked_q;
    logic                   all_locked_d;

    // Slip offset advance; wraps explicitly so non-power-of-two DW works too.
    function automatic logic [SW-1:0] slip_inc(input logic [SW-1:0] s);
        if (s == SLIP_LAST) begin
            return {SW{1'b0}};
        end else begin
            return s + SW'(1);
        end
    endfunction

    // Saturating counter increment so a counter can never wrap to zero.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        if (c == CNT_MAX) begin
            return c;
        end else begin
            return c + CNT_ONE;
        end
    endfunction

    // Per-lane window extraction, alignment FSM and next-state datapath.
    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = din_vld;
        for (int i = 0; i < LANES; i++) begin
            state_d[i]     = state_q[i];
            slip_d[i]      = slip_q[i];
            match_cnt_d[i] = match_cnt_q[i];
            err_cnt_d[i]   = err_cnt_q[i];
            prev_d[i]      = prev_q[i];

            // Older word in the LSBs, so a larger slip selects later bits.
            win_s[i]     = {din[i*DW +: DW], prev_q[i]};
            aligned_s[i] = DW'(win_s[i] >> slip_q[i]);
            match_s[i]   = (aligned_s[i] == TRAIN);

            if (din_vld) begin
                prev_d[i]          = din[i*DW +: DW];
                dout_d[i*DW +: DW] = aligned_s[i];
            end else begin
                prev_d[i] = prev_q[i];
            end

            if (realign) begin
                // The realign word still moves data, but it is never scored.
                state_d[i]     = ST_SEARCH;
                match_cnt_d[i] = {CW{1'b0}};
                err_cnt_d[i]   = {CW{1'b0}};
            end else if (din_vld && train_en) begin
                case (state_q[i])
                    ST_SEARCH: begin
                        if (match_s[i]) begin
                            match_cnt_d[i] = CNT_ONE;
                            if (LOCK_CNT == 32'sd1) begin
                                state_d[i]     = ST_LOCKED;
                                match_cnt_d[i] = {CW{1'b0}};
                            end else begin
                                state_d[i] = ST_CHECK;
                            end
                        end else begin
                            slip_d[i] = slip_inc(slip_q[i]);
                        end
                    end
                    ST_CHECK: begin
                        if (match_s[i]) begin
                            match_cnt_d[i] = sat_inc(match_cnt_q[i]);
                            if (match_cnt_d[i] >= LOCK_C) begin
                                state_d[i]     = ST_LOCKED;
                                match_cnt_d[i] = {CW{1'b0}};
                                err_cnt_d[i]   = {CW{1'b0}};
                            end else begin
                                state_d[i] = ST_CHECK;
                            end
                        end else begin
                            state_d[i]     = ST_SEARCH;
                            slip_d[i]      = slip_inc(slip_q[i]);
                            match_cnt_d[i] = {CW{1'b0}};
                        end
                    end
                    ST_LOCKED: begin
                        if (match_s[i]) begin
                            err_cnt_d[i] = {CW{1'b0}};
                        end else begin
                            err_cnt_d[i] = sat_inc(err_cnt_q[i]);
                            if (err_cnt_d[i] >= UNLOCK_C) begin
                                // Slip is kept: the link most likely glitched,
                                // and it did not drift a full bit.
                                state_d[i]     = ST_SEARCH;
                                match_cnt_d[i] = {CW{1'b0}};
                                err_cnt_d[i]   = {CW{1'b0}};
                            end else begin
                                state_d[i] = ST_LOCKED;
                            end
                        end
                    end
                    default: begin
                        state_d[i]     = ST_SEARCH;
                        match_cnt_d[i] = {CW{1'b0}};
                        err_cnt_d[i]   = {CW{1'b0}};
                    end
                endcase
            end else begin
                // Payload or idle cycle: the alignment state is frozen.
                state_d[i] = state_q[i];
            end

            locked_d[i] = (state_d[i] == ST_LOCKED);
        end
        all_locked_d = &locked_d;
    end

    // State, counter, window history and output registers with sync reset.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i]     <= ST_SEARCH;
                slip_q[i]      <= {SW{1'b0}};
                match_cnt_q[i] <= {CW{1'b0}};
                err_cnt_q[i]   <= {CW{1'b0}};
                prev_q[i]      <= {DW{1'b0}};
            end
            dout_q       <= {(LANES*DW){1'b0}};
            dout_vld_q   <= 1'b0;
            locked_q     <= {LANES{1'b0}};
            all_locked_q <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i]     <= state_d[i];
                slip_q[i]      <= slip_d[i];
                match_cnt_q[i] <= match_cnt_d[i];
                err_cnt_q[i]   <= err_cnt_d[i];
                prev_q[i]      <= prev_d[i];
            end
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            locked_q     <= locked_d;
            all_locked_q <= all_locked_d;
        end
    end

    // Drive the ports straight from registers, packing slip offsets lane-wise.
    always_comb begin
        dout        = dout_q;
        dout_vld    = dout_vld_q;
        lane_locked = locked_q;
        all_locked  = all_locked_q;
        slip_pos    = {(LANES*SW){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            slip_pos[i*SW +: SW] = slip_q[i];
        end
    end

endmodule

// File: tb/tb_fpga_iser_align.sv
// Scoreboard bench for fpga_iser_align. The stimulus thread runs a
// behavioural model of every lane and pushes the expected outputs for each
// valid word. A monitor pops one entry and compares it whenever dout_vld is
// high.
module tb_fpga_iser_align;

    localparam int            DW         = 8;
    localparam int            LANES      = 4;
    localparam int            SW         = 3;
    localparam int            LOCK_CNT   = 16;
    localparam int            UNLOCK_CNT = 4;
    localparam logic [DW-1:0] TRAIN      = 8'h6A;

    logic                   clk = 1'b0;
    logic                   srst = 1'b1;
    logic [LANES*DW-1:0]    din = '0;
    logic                   din_vld = 1'b0;
    logic                   train_en = 1'b0;
    logic                   realign = 1'b0;
    logic [LANES*DW-1:0]    dout;
    logic                   dout_vld;
    logic [LANES-1:0]       lane_locked;
    logic                   all_locked;
    logic [LANES*SW-1:0]    slip_pos;

    always #5 clk = ~clk;

    fpga_iser_align #(
        .DW(DW), .LANES(LANES), .TRAIN(TRAIN),
        .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT)
    ) dut (
        .clk(clk), .srst(srst), .din(din), .din_vld(din_vld),
        .train_en(train_en), .realign(realign), .dout(dout),
        .dout_vld(dout_vld), .lane_locked(lane_locked),
        .all_locked(all_locked), .slip_pos(slip_pos)
    );

    typedef struct packed {
        logic [LANES*DW-1:0] dout;
        logic [LANES-1:0]    locked;
        logic [LANES*SW-1:0] slip;
        logic                all;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: a lane is either hunting (it counts a run of
    // consecutive matches) or locked (it counts a run of consecutive misses).
    bit            m_lock [LANES];
    int            m_run  [LANES];
    int            m_miss [LANES];
    int            m_slip [LANES];
    logic [DW-1:0] m_prev [LANES];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] v, input int k);
        int x;
        x = (int'(v) << k) | (int'(v) >> (DW - k));
        return 8'(x);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            m_lock[i] = 1'b0;
            m_run[i]  = 0;
            m_miss[i] = 0;
            m_slip[i] = 0;
            m_prev[i] = '0;
        end
    endtask

    // Apply one cycle of stimulus, advance the model, and queue the expectation.
    task automatic drive(input logic [LANES*DW-1:0] d, input logic v, input logic t, input logic r);
        exp_t e;
        e = '0;
        srst = 1'b0; din = d; din_vld = v; train_en = t; realign = r;
        for (int i = 0; i < LANES; i++) begin
            logic [DW-1:0] word;
            int            w;
            logic [DW-1:0] al;
            word = d[i*DW +: DW];
            w    = (int'(word) << DW) | int'(m_prev[i]);
            al   = 8'((w >> m_slip[i]) & 255);
            e.dout[i*DW +: DW] = al;
            if (r) begin
                m_lock[i] = 1'b0; m_run[i] = 0; m_miss[i] = 0;
            end else if (v && t) begin
                if (!m_lock[i]) begin
                    if (al == TRAIN) begin
                        m_run[i]++;
                        if (m_run[i] >= LOCK_CNT) begin
                            m_lock[i] = 1'b1; m_run[i] = 0; m_miss[i] = 0;
                        end
                    end else begin
                        m_run[i]  = 0;
                        m_slip[i] = (m_slip[i] + 1) % DW;
                    end
                end else begin
                    if (al == TRAIN) begin
                        m_miss[i] = 0;
                    end else begin
                        m_miss[i]++;
                        if (m_miss[i] >= UNLOCK_CNT) begin
                            m_lock[i] = 1'b0; m_miss[i] = 0; m_run[i] = 0;
                        end
                    end
                end
            end
            if (v) m_prev[i] = word;
            e.locked[i]         = m_lock[i];
            e.slip[i*SW +: SW]  = 3'(m_slip[i]);
        end
        e.all = &e.locked;
        if (v) sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Issue n valid words from per-lane patterns, with random idle gaps between them.
    task automatic words(input int n, input logic [LANES*DW-1:0] pat, input logic [LANES-1:0] rnd,
                         input logic t);
        logic [LANES*DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            while ($urandom_range(0, 3) == 0) drive({$urandom, $urandom}, 1'b0, t, 1'b0);
            d = pat;
            for (int i = 0; i < LANES; i++)
                if (rnd[i]) d[i*DW +: DW] = 8'($urandom);
            drive(d, 1'b1, t, 1'b0);
        end
    endtask

    task automatic do_reset(input int cycles);
        srst = 1'b1; realign = 1'b0; train_en = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            din = {$urandom, $urandom}; din_vld = 1'b1;
            @(posedge clk);
            #1;
            check("rst_dout", 64'(dout), 64'd0);
            check("rst_dout_vld", 64'(dout_vld), 64'd0);
            check("rst_locked", 64'(lane_locked), 64'd0);
            check("rst_all_locked", 64'(all_locked), 64'd0);
            check("rst_slip", 64'(slip_pos), 64'd0);
        end
        model_reset();
    endtask

    // Scoreboard monitor: one queued expectation per presented output word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (dout_vld === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL spurious_vld: got dout_vld=1 expected no output at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("dout", 64'(dout), 64'(e.dout));
                    check("lane_locked", 64'(lane_locked), 64'(e.locked));
                    check("slip_pos", 64'(slip_pos), 64'(e.slip));
                    check("all_locked", 64'(all_locked), 64'(e.all));
                end
            end
        end
    end

    initial begin
        logic [LANES*DW-1:0] pat;
        logic [DW-1:0]       r3, bad;
        int                  skew [LANES];

        // Reset, with random din and din_vld held high
        do_reset(4);
        drive({$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
        check("first_vld_latency", 64'(dout_vld), 64'd1);
        drive({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);
        check("vld_drop", 64'(dout_vld), 64'd0);

        // Lane 0 carries TRAIN rotated by 3 bits; the other lanes carry noise
        do_reset(2);
        r3  = rotl(TRAIN, 3);
        pat = '0;
        pat[DW-1:0] = r3;
        words(18, pat, 4'b1110, 1'b1);
        check("lock_not_early", 64'(lane_locked[0]), 64'd0);
        words(1, pat, 4'b1110, 1'b1);
        check("lock_after_16", 64'(lane_locked[0]), 64'd1);
        check("slip_settle", 64'(slip_pos[SW-1:0]), 64'd3);
        words(10, pat, 4'b1110, 1'b1);
        check("aligned_train", 64'(dout[DW-1:0]), 64'(TRAIN));

        // Three bad words, then a good one, keep lock; four bad words drop it
        bad = r3 ^ 8'h01;
        pat[DW-1:0] = bad;
        words(3, pat, 4'b1110, 1'b1);
        pat[DW-1:0] = r3;
        words(1, pat, 4'b1110, 1'b1);
        check("lock_survives_3", 64'(lane_locked[0]), 64'd1);
        pat[DW-1:0] = bad;
        words(4, pat, 4'b1110, 1'b1);
        check("unlock_after_4", 64'(lane_locked[0]), 64'd0);
        check("unlock_slip_kept", 64'(slip_pos[SW-1:0]), 64'd3);

        // Relock, then carry random payload with training off
        pat[DW-1:0] = r3;
        words(20, pat, 4'b1110, 1'b1);
        check("relock", 64'(lane_locked[0]), 64'd1);
        words(1000, '0, 4'b1111, 1'b0);
        check("payload_hold", 64'(lane_locked[0]), 64'd1);

        // Four lanes skewed by 0, 2, 5 and 7 bits; the skew-0 lane has to wrap 7 -> 0
        do_reset(2);
        skew[0] = 0; skew[1] = 2; skew[2] = 5; skew[3] = 7;
        for (int i = 0; i < LANES; i++) pat[i*DW +: DW] = rotl(TRAIN, skew[i]);
        words(23, pat, 4'b0000, 1'b1);
        check("all_not_early", 64'(all_locked), 64'd0);
        words(1, pat, 4'b0000, 1'b1);
        check("all_locked_last", 64'(all_locked), 64'd1);
        check("skew_slips", 64'(slip_pos), 64'hF50);
        drive(pat, 1'b1, 1'b1, 1'b1);
        check("realign_drop", 64'(all_locked), 64'd0);
        check("realign_lanes", 64'(lane_locked), 64'd0);
        words(15, pat, 4'b0000, 1'b1);
        check("relock_not_early", 64'(all_locked), 64'd0);
        words(1, pat, 4'b0000, 1'b1);
        check("relock_all", 64'(all_locked), 64'd1);

        drive('0, 1'b0, 1'b1, 1'b0);
        drive('0, 1'b0, 1'b1, 1'b0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
